// File: rtl/vending_machine_param.sv
// vending_machine_param
//   Coin-operated vending controller with a configurable item price. Coins
//   accumulate credit until the price is reached. A single-cycle vend pulse
//   is then issued, and the remainder is paid back one coin per cycle,
//   largest coin first.
//
//   Optional feature macro: VM_REFUND_EN
//     Adds the cancel input. Asserting cancel while collecting refunds the
//     credit without vending.
//
// Parameters
//   PRICE   item price in coin units (1..255)
//
// Ports
//   clk     single clock, rising edge
//   rst     synchronous active-high reset
//   in      coin code: 00 none, 01 = 1, 10 = 2, 11 = 4 units
//   cancel  refund request (only with VM_REFUND_EN)
//   out     registered one-cycle vend pulse
//   change  registered change coin this cycle: 00 none, 01 = 1, 10 = 2
//   busy    high while vending or paying change
//   credit  current credit or remaining change, in units
module vending_machine_param #(
    parameter  int unsigned PRICE = 3,
    localparam int unsigned CW    = $clog2(PRICE + 4)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    in,
`ifdef VM_REFUND_EN
    input  logic          cancel,
`endif
    output logic          out,
    output logic [1:0]    change,
    output logic          busy,
    output logic [CW-1:0] credit
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] credit_q;
    logic [CW-1:0] credit_n;
    logic          out_n;
    logic [1:0]    change_n;
    logic [CW-1:0] coin_val;
    logic [CW-1:0] sum;
    logic          refund;
    logic          pay;

    always_comb begin
        coin_val = '0;
        case (in)
            2'b01:   coin_val = CW'(1);
            2'b10:   coin_val = CW'(2);
            2'b11:   coin_val = CW'(4);
            default: coin_val = '0;
        endcase
    end

    // Credit never exceeds PRICE-1 while collecting, so the sum tops out at
    // PRICE+3, which CW is sized to hold.
    assign sum = credit_q + coin_val;

`ifdef VM_REFUND_EN
    assign refund = cancel && (state == COLLECT);
`else
    assign refund = 1'b0;
`endif

    // A refund enters the payout path directly, so the first change coin
    // appears on the cancel edge, just as it would in VEND.
    assign pay = (state == VEND) || (state == CHANGE) || refund;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            credit_q <= '0;
            out      <= 1'b0;
            change   <= 2'b00;
        end else begin
            state    <= state_n;
            credit_q <= credit_n;
            out      <= out_n;
            change   <= change_n;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_n  = state;
        credit_n = credit_q;
        out_n    = 1'b0;
        change_n = 2'b00;
        if (pay) begin
            if (credit_q >= CW'(2)) begin
                change_n = 2'b10;
                credit_n = credit_q - CW'(2);
                state_n  = CHANGE;
            end else if (credit_q == CW'(1)) begin
                change_n = 2'b01;
                credit_n = '0;
                state_n  = CHANGE;
            end else begin
                state_n  = IDLE;
            end
        end else if (in != 2'b00) begin
            if (sum >= PRICE_C) begin
                out_n    = 1'b1;
                credit_n = sum - PRICE_C;
                state_n  = VEND;
            end else begin
                credit_n = sum;
                state_n  = COLLECT;
            end
        end
    end

    // Combinational outputs
    always_comb begin
        busy   = (state == VEND) || (state == CHANGE);
        credit = credit_q;
    end

endmodule

// File: tb/tb_vending_machine_param.sv
module tb_vending_machine_param;

    localparam int unsigned PR[4] = '{3, 1, 5, 7};
`ifdef VM_REFUND_EN
    localparam bit REF = 1'b1;
`else
    localparam bit REF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_a    [4];
    logic [1:0] in_a     [4];
`ifdef VM_REFUND_EN
    logic       cancel_a [4];
`endif
    logic       out_a    [4];
    logic [1:0] change_a [4];
    logic       busy_a   [4];
    logic [7:0] credit_a [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned CWG = $clog2(PR[g] + 4);
        logic [CWG-1:0] cr;
        vending_machine_param #(.PRICE(PR[g])) dut (
            .clk    (clk),
            .rst    (rst_a[g]),
            .in     (in_a[g]),
`ifdef VM_REFUND_EN
            .cancel (cancel_a[g]),
`endif
            .out    (out_a[g]),
            .change (change_a[g]),
            .busy   (busy_a[g]),
            .credit (cr)
        );
        assign credit_a[g] = 8'(cr);
    end

    // Reference model: credit as a plain integer plus a queue of the
    // per-cycle outputs still owed once a payout has been decided.
    typedef struct {
        logic       o;
        logic [1:0] c;
        logic       b;
        int         cr;
    } exp_t;

    int   m_cr [4];
    exp_t mq   [4][$];

    logic       e_out;
    logic [1:0] e_chg;
    logic       e_busy;
    int         e_cr;

    int checks = 0;
    int fails  = 0;

    task automatic payout(input int i, input int r, input bit now);
        int  rem;
        bit  first;
        rem   = r;
        first = now;
        while (rem > 0) begin
            int c;
            c   = (rem >= 2) ? 2 : 1;
            rem = rem - c;
            if (first) begin
                e_chg   = c[1:0];
                e_busy  = 1'b1;
                m_cr[i] = rem;
                first   = 1'b0;
            end else begin
                mq[i].push_back('{1'b0, c[1:0], 1'b1, rem});
            end
        end
        mq[i].push_back('{1'b0, 2'b00, 1'b0, 0});
    endtask

    // Drive one cycle on instance i, advance the model, sample after the edge.
    task automatic step(input int i, input logic [1:0] coin, input logic cnl, input logic r);
        exp_t x;
        int   v;
        int   s;
        in_a[i]  = coin;
        rst_a[i] = r;
`ifdef VM_REFUND_EN
        cancel_a[i] = cnl;
`endif
        @(posedge clk);
        #1;
        e_out  = 1'b0;
        e_chg  = 2'b00;
        e_busy = 1'b0;
        if (r) begin
            mq[i].delete();
            m_cr[i] = 0;
        end else if (mq[i].size() > 0) begin
            x       = mq[i].pop_front();
            e_out   = x.o;
            e_chg   = x.c;
            e_busy  = x.b;
            m_cr[i] = x.cr;
        end else if (REF && cnl && m_cr[i] > 0) begin
            payout(i, m_cr[i], 1'b1);
        end else begin
            v = (coin == 2'b11) ? 4 : int'(coin);
            if (v != 0) begin
                s = m_cr[i] + v;
                if (s < int'(PR[i])) begin
                    m_cr[i] = s;
                end else begin
                    e_out   = 1'b1;
                    e_busy  = 1'b1;
                    m_cr[i] = s - int'(PR[i]);
                    payout(i, m_cr[i], 1'b0);
                end
            end
        end
        e_cr     = m_cr[i];
        in_a[i]  = 2'b00;
        rst_a[i] = 1'b0;
`ifdef VM_REFUND_EN
        cancel_a[i] = 1'b0;
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b1;
            in_a[i]  = 2'b11;
            m_cr[i]  = 0;
            mq[i].delete();
`ifdef VM_REFUND_EN
            cancel_a[i] = 1'b0;
`endif
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_a[i], change_a[i], busy_a[i], credit_a[i]} !== 12'h000) begin
                fails++;
                $display("FAIL reset[%0d]: got out=%b chg=%b busy=%b credit=%0d, exp all zero",
                         i, out_a[i], change_a[i], busy_a[i], credit_a[i]);
            end
            rst_a[i] = 1'b0;
            in_a[i]  = 2'b00;
        end
    endtask

    // Stimulus words are {rst, cancel, in}.
    task automatic test_single_coin();
        bit [3:0] s[$] = '{4'h8, 4'h3, 4'h0, 4'h0, 4'h0};
        foreach (s[k]) begin
            step(0, s[k][1:0], s[k][2], s[k][3]);
            checks++;
            if ({out_a[0], change_a[0], busy_a[0], credit_a[0]} !== {e_out, e_chg, e_busy, 8'(e_cr)}) begin
                fails++;
                $display("FAIL single_coin step %0d: got out=%b chg=%b busy=%b credit=%0d, exp out=%b chg=%b busy=%b credit=%0d",
                         k, out_a[0], change_a[0], busy_a[0], credit_a[0], e_out, e_chg, e_busy, e_cr);
            end
        end
    endtask

    task automatic test_exact_pay();
        bit [3:0] s[$] = '{4'h8, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        foreach (s[k]) begin
            step(0, s[k][1:0], s[k][2], s[k][3]);
            checks++;
            if ({out_a[0], change_a[0], busy_a[0], credit_a[0]} !== {e_out, e_chg, e_busy, 8'(e_cr)}) begin
                fails++;
                $display("FAIL exact_pay step %0d: got out=%b chg=%b busy=%b credit=%0d, exp out=%b chg=%b busy=%b credit=%0d",
                         k, out_a[0], change_a[0], busy_a[0], credit_a[0], e_out, e_chg, e_busy, e_cr);
            end
        end
    endtask

    task automatic test_large_change();
        bit [3:0] s[$] = '{4'h8, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        foreach (s[k]) begin
            step(1, s[k][1:0], s[k][2], s[k][3]);
            checks++;
            if ({out_a[1], change_a[1], busy_a[1], credit_a[1]} !== {e_out, e_chg, e_busy, 8'(e_cr)}) begin
                fails++;
                $display("FAIL large_change step %0d: got out=%b chg=%b busy=%b credit=%0d, exp out=%b chg=%b busy=%b credit=%0d",
                         k, out_a[1], change_a[1], busy_a[1], credit_a[1], e_out, e_chg, e_busy, e_cr);
            end
        end
    endtask

    task automatic test_busy_ignore();
        bit [3:0] s[$] = '{4'h8, 4'h2, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0};
        foreach (s[k]) begin
            step(2, s[k][1:0], s[k][2], s[k][3]);
            checks++;
            if ({out_a[2], change_a[2], busy_a[2], credit_a[2]} !== {e_out, e_chg, e_busy, 8'(e_cr)}) begin
                fails++;
                $display("FAIL busy_ignore step %0d: got out=%b chg=%b busy=%b credit=%0d, exp out=%b chg=%b busy=%b credit=%0d",
                         k, out_a[2], change_a[2], busy_a[2], credit_a[2], e_out, e_chg, e_busy, e_cr);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit [3:0] s[$] = '{4'h8, 4'h2, 4'h9, 4'h1, 4'h0,
                           4'h3, 4'h0, 4'h8, 4'h0};
        foreach (s[k]) begin
            step(0, s[k][1:0], s[k][2], s[k][3]);
            checks++;
            if ({out_a[0], change_a[0], busy_a[0], credit_a[0]} !== {e_out, e_chg, e_busy, 8'(e_cr)}) begin
                fails++;
                $display("FAIL reset_mid step %0d: got out=%b chg=%b busy=%b credit=%0d, exp out=%b chg=%b busy=%b credit=%0d",
                         k, out_a[0], change_a[0], busy_a[0], credit_a[0], e_out, e_chg, e_busy, e_cr);
            end
        end
    endtask

    task automatic test_hold();
        bit [3:0] s[$];
        s = '{4'h8, 4'h1};
        for (int n = 0; n < 12; n++) s.push_back(4'h0);
        s.push_back(4'h2);
        s.push_back(4'h3);
        s.push_back(4'h0);
        s.push_back(4'h0);
        foreach (s[k]) begin
            step(3, s[k][1:0], s[k][2], s[k][3]);
            checks++;
            if ({out_a[3], change_a[3], busy_a[3], credit_a[3]} !== {e_out, e_chg, e_busy, 8'(e_cr)}) begin
                fails++;
                $display("FAIL hold step %0d: got out=%b chg=%b busy=%b credit=%0d, exp out=%b chg=%b busy=%b credit=%0d",
                         k, out_a[3], change_a[3], busy_a[3], credit_a[3], e_out, e_chg, e_busy, e_cr);
            end
        end
    endtask

`ifdef VM_REFUND_EN
    task automatic test_refund();
        bit [3:0] s[$] = '{4'h8, 4'h2, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0,
                           4'h8, 4'h5, 4'h4, 4'h0, 4'h0};
        foreach (s[k]) begin
            step(3, s[k][1:0], s[k][2], s[k][3]);
            checks++;
            if ({out_a[3], change_a[3], busy_a[3], credit_a[3]} !== {e_out, e_chg, e_busy, 8'(e_cr)}) begin
                fails++;
                $display("FAIL refund step %0d: got out=%b chg=%b busy=%b credit=%0d, exp out=%b chg=%b busy=%b credit=%0d",
                         k, out_a[3], change_a[3], busy_a[3], credit_a[3], e_out, e_chg, e_busy, e_cr);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            step(i, 2'b00, 1'b0, 1'b1);
            for (int k = 0; k < 300; k++) begin
                logic [1:0] coin;
                logic       cnl;
                logic       r;
                coin = 2'($urandom % 4);
                cnl  = REF && ($urandom % 5 == 0);
                r    = ($urandom % 50 == 0);
                step(i, coin, cnl, r);
                checks++;
                if ({out_a[i], change_a[i], busy_a[i], credit_a[i]} !== {e_out, e_chg, e_busy, 8'(e_cr)}) begin
                    fails++;
                    $display("FAIL random[%0d] step %0d: got out=%b chg=%b busy=%b credit=%0d, exp out=%b chg=%b busy=%b credit=%0d",
                             i, k, out_a[i], change_a[i], busy_a[i], credit_a[i], e_out, e_chg, e_busy, e_cr);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b0;
            in_a[i]  = 2'b00;
`ifdef VM_REFUND_EN
            cancel_a[i] = 1'b0;
`endif
        end
        #2;
        test_reset();
        test_single_coin();
        test_exact_pay();
        test_large_change();
        test_busy_ignore();
        test_reset_mid();
        test_hold();
`ifdef VM_REFUND_EN
        test_refund();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
